// File: rtl/flexbyte_sr_ctrl.sv
// Sequencing controller for flexbyte_stp_sr: drives shift_enable from a valid/ready chunk stream and presents assembled words.
// Optional short-message flush with zero padding is enabled by defining FLEXBYTE_CTRL_FLUSH_EN.
module flexbyte_sr_ctrl #(
   parameter int IN_BYTES  = 1,
   parameter int OUT_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic                         shift_enable,
   output logic                         pad_zero,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic [$clog2(OUT_BYTES):0]   out_count
);
   localparam int SHIFTS = OUT_BYTES / IN_BYTES;
   localparam int CNT_W  = $clog2(SHIFTS + 1);
   localparam int OC_W   = $clog2(OUT_BYTES) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FULL  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] base;
   logic             in_hs;

`ifdef FLEXBYTE_CTRL_FLUSH_EN
   logic [CNT_W-1:0] real_q, real_d;
   logic             last_q, last_d;
`else
   logic             unused_in_last;
   assign unused_in_last = in_last;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
         real_q  <= '0;
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
         real_q  <= real_d;
         last_q  <= last_d;
`endif
      end
   end

   // A chunk accepted in FULL is the first of the next word, so counting restarts from zero there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
      real_d  = real_q;
      last_d  = last_q;
`endif
      base = (state_q == FULL) ? '0 : cnt_q;
      if (in_hs) begin
         if (base == LAST_CNT) begin
            state_d = FULL;
            cnt_d   = '0;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
            real_d  = CNT_W'(SHIFTS);
            last_d  = in_last;
`endif
         end else begin
            state_d = FILL;
            cnt_d   = base + ONE;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
            if (in_last) begin
               state_d = FLUSH;
               real_d  = base + ONE;
            end
`endif
         end
      end else if (state_q == FULL && out_ready) begin
         state_d = FILL;
         cnt_d   = '0;
      end
`ifdef FLEXBYTE_CTRL_FLUSH_EN
      else if (state_q == FLUSH) begin
         if (cnt_q == LAST_CNT) begin
            state_d = FULL;
            cnt_d   = '0;
            last_d  = 1'b1;
         end else begin
            cnt_d   = cnt_q + ONE;
         end
      end
`endif
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      pad_zero  = 1'b0;
      unique case (state_q)
         FILL: in_ready = 1'b1;
         FULL: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
`ifdef FLEXBYTE_CTRL_FLUSH_EN
         FLUSH: pad_zero = 1'b1;
`endif
         default: ;
      endcase
      in_hs        = in_valid & in_ready;
      shift_enable = in_hs | pad_zero;
   end

`ifdef FLEXBYTE_CTRL_FLUSH_EN
   assign out_last  = out_valid & last_q;
   assign out_count = out_valid ? OC_W'(int'(real_q) * IN_BYTES) : '0;
`else
   assign out_last  = 1'b0;
   assign out_count = OC_W'(OUT_BYTES);
`endif

endmodule

// File: tb/tb_flexbyte_sr_ctrl.sv
// Bench for flexbyte_sr_ctrl: three instances (1, 2 and 4 bytes per shift into a 4-byte word) share one stimulus
// stream and are each scored against a chunk/word-level reference model that also plays the shift register.
module tb_flexbyte_sr_ctrl;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic        tb_clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] din = '0;

   logic       ir[3], se[3], pz[3], ov[3], ol[3];
   logic [2:0] oc[3];

   always #5 tb_clk = ~tb_clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      flexbyte_sr_ctrl #(.IN_BYTES(1 << g), .OUT_BYTES(4)) u_dut (
         .clk(tb_clk), .n_rst(n_rst), .in_valid(in_valid), .in_last(in_last),
         .in_ready(ir[g]), .shift_enable(se[g]), .pad_zero(pz[g]), .out_valid(ov[g]),
         .out_ready(out_ready), .out_last(ol[g]), .out_count(oc[g]));
   end

   // Reference model: partial word being gathered, pending pad shifts, and the word on offer.
   int          p_cnt[3], pads[3], real_c[3], pc[3];
   logic [31:0] p_word[3], pw[3], sr[3];
   bit          pv[3], pl[3];
   int          total = 0;
   int          bad = 0;

   function automatic int shifts_of(int k);
      return 4 >> k;
   endfunction

   function automatic logic [31:0] chunk_of(int k, logic [31:0] d);
      case (k)
         0:       return {24'h0, d[7:0]};
         1:       return {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] shin(logic [31:0] w, int k, logic [31:0] c);
      if (k == 2) return c;
      return (w << (8 << k)) | c;
   endfunction

   function automatic bit exp_ir(int k);
      return (pads[k] == 0) && (!pv[k] || out_ready);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         p_cnt[k] = 0; pads[k] = 0; real_c[k] = 0; pc[k] = 0;
         p_word[k] = '0; pw[k] = '0; pv[k] = 1'b0; pl[k] = 1'b0;
      end
   endtask

   task automatic drive(input bit iv, input bit il, input bit ordy, input logic [31:0] d);
      @(negedge tb_clk);
      in_valid = iv; in_last = il; out_ready = ordy; din = d;
      #1;
   endtask

   task automatic scoreboard_cycle();
      for (int k = 0; k < 3; k++) begin
         bit       e_ir, e_se, e_pz, e_ol;
         logic [2:0] e_oc;
         e_ir = exp_ir(k);
         e_se = (in_valid && e_ir) || (pads[k] > 0);
         e_pz = pads[k] > 0;
         e_ol = FL && pv[k] && pl[k];
         e_oc = FL ? (pv[k] ? 3'(pc[k]) : 3'd0) : 3'd4;
         total += 6;
         if (ov[k] !== pv[k]) begin
            bad++; $display("FAIL out_valid[%0d] t=%0t got=%b want=%b", k, $time, ov[k], pv[k]);
         end
         if (ir[k] !== e_ir) begin
            bad++; $display("FAIL in_ready[%0d] t=%0t got=%b want=%b", k, $time, ir[k], e_ir);
         end
         if (se[k] !== e_se) begin
            bad++; $display("FAIL shift_enable[%0d] t=%0t got=%b want=%b", k, $time, se[k], e_se);
         end
         if (pz[k] !== e_pz) begin
            bad++; $display("FAIL pad_zero[%0d] t=%0t got=%b want=%b", k, $time, pz[k], e_pz);
         end
         if (ol[k] !== e_ol) begin
            bad++; $display("FAIL out_last[%0d] t=%0t got=%b want=%b", k, $time, ol[k], e_ol);
         end
         if (oc[k] !== e_oc) begin
            bad++; $display("FAIL out_count[%0d] t=%0t got=%0d want=%0d", k, $time, oc[k], e_oc);
         end
         if (pv[k]) begin
            total++;
            if (sr[k] !== pw[k]) begin
               bad++; $display("FAIL word[%0d] t=%0t got=%h want=%h", k, $time, sr[k], pw[k]);
            end
         end
      end
   endtask

   // Advance one clock edge: the bench shift register follows the DUT's shift_enable/pad_zero.
   task automatic tick();
      @(posedge tb_clk);
      for (int k = 0; k < 3; k++) begin
         bit acc;
         acc = in_valid && exp_ir(k);
         if (se[k] === 1'b1) sr[k] = shin(sr[k], k, (pz[k] === 1'b1) ? 32'h0 : chunk_of(k, din));
         if (pv[k] && out_ready) pv[k] = 1'b0;
         if (acc) begin
            p_word[k] = shin(p_word[k], k, chunk_of(k, din));
            p_cnt[k]++;
            if (p_cnt[k] == shifts_of(k)) begin
               pv[k] = 1'b1; pw[k] = p_word[k]; pc[k] = 4; pl[k] = FL && in_last;
               p_cnt[k] = 0; p_word[k] = '0;
            end else if (FL && in_last) begin
               real_c[k] = p_cnt[k]; pads[k] = shifts_of(k) - p_cnt[k];
            end
         end else if (pads[k] > 0) begin
            p_word[k] = shin(p_word[k], k, 32'h0);
            pads[k]--; p_cnt[k]++;
            if (pads[k] == 0) begin
               pv[k] = 1'b1; pw[k] = p_word[k]; pc[k] = real_c[k] * (1 << k); pl[k] = 1'b1;
               p_cnt[k] = 0; p_word[k] = '0;
            end
         end
      end
   endtask

   task automatic cycle(input bit iv, input bit il, input bit ordy, input logic [31:0] d);
      drive(iv, il, ordy, d);
      scoreboard_cycle();
      tick();
   endtask

   task automatic apply_reset();
      @(negedge tb_clk);
      n_rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      model_reset();
      @(posedge tb_clk);
      @(negedge tb_clk);
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         total += 5;
         if (ov[k] !== 1'b0) begin bad++; $display("FAIL rst_out_valid[%0d] got=%b want=0", k, ov[k]); end
         if (ol[k] !== 1'b0) begin bad++; $display("FAIL rst_out_last[%0d] got=%b want=0", k, ol[k]); end
         if (pz[k] !== 1'b0) begin bad++; $display("FAIL rst_pad_zero[%0d] got=%b want=0", k, pz[k]); end
         if (se[k] !== 1'b0) begin bad++; $display("FAIL rst_shift_enable[%0d] got=%b want=0", k, se[k]); end
         if (oc[k] !== (FL ? 3'd0 : 3'd4)) begin
            bad++; $display("FAIL rst_out_count[%0d] got=%0d want=%0d", k, oc[k], FL ? 0 : 4);
         end
      end
      tick();
   endtask

   task automatic test_fill_hold();
      apply_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      scoreboard_cycle();
      total += 3;
      if (ov[0] !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b want=1", ov[0]); end
      if (sr[0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hold_word got=%h want=ffffffff", sr[0]); end
      if (ir[0] !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%b want=0", ir[0]); end
      tick();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h1234_5678);
   endtask

   task automatic test_stream();
      int pulses;
      apply_reset();
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 1'b1, 32'h0101_0101 * (i + 1));
         scoreboard_cycle();
         if (ov[0] === 1'b1) pulses++;
         tick();
      end
      total++;
      if (pulses != 3) begin bad++; $display("FAIL stream_pulses got=%0d want=3", pulses); end
   endtask

   task automatic test_two_byte();
      apply_reset();
      cycle(1'b1, 1'b0, 1'b0, 32'h0000_0F08);
      cycle(1'b1, 1'b0, 1'b0, 32'h0000_0000);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      scoreboard_cycle();
      total += 3;
      if (ov[1] !== 1'b1) begin bad++; $display("FAIL in2_valid got=%b want=1", ov[1]); end
      if (sr[1] !== 32'h0F08_0000) begin bad++; $display("FAIL in2_word got=%h want=0f080000", sr[1]); end
      if (oc[1] !== 3'd4) begin bad++; $display("FAIL in2_count got=%0d want=4", oc[1]); end
      tick();
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic test_flush();
      apply_reset();
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_00AA);
      cycle(1'b1, 1'b0, 1'b1, 32'h0000_00BB);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_00CC);
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      scoreboard_cycle();
      total += 2;
`ifdef FLEXBYTE_CTRL_FLUSH_EN
      if (pz[0] !== 1'b1) begin bad++; $display("FAIL flush_pad got=%b want=1", pz[0]); end
      if (ir[0] !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", ir[0]); end
`else
      if (pz[0] !== 1'b0) begin bad++; $display("FAIL noflush_pad got=%b want=0", pz[0]); end
      if (ov[0] !== 1'b0) begin bad++; $display("FAIL noflush_valid got=%b want=0", ov[0]); end
`endif
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      scoreboard_cycle();
`ifdef FLEXBYTE_CTRL_FLUSH_EN
      total += 4;
      if (ov[0] !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b want=1", ov[0]); end
      if (sr[0] !== 32'hAABB_CC00) begin bad++; $display("FAIL flush_word got=%h want=aabbcc00", sr[0]); end
      if (oc[0] !== 3'd3) begin bad++; $display("FAIL flush_count got=%0d want=3", oc[0]); end
      if (ol[0] !== 1'b1) begin bad++; $display("FAIL flush_last got=%b want=1", ol[0]); end
`else
      total++;
      if (ov[0] !== 1'b0) begin bad++; $display("FAIL noflush_wait got=%b want=0", ov[0]); end
`endif
      tick();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   task automatic test_reset_midword();
      apply_reset();
      cycle(1'b1, 1'b0, 1'b0, 32'h1111_1111);
      cycle(1'b1, 1'b0, 1'b0, 32'h2222_2222);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      n_rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         total += 2;
         if (ov[k] !== 1'b0) begin bad++; $display("FAIL midrst_valid[%0d] got=%b want=0", k, ov[k]); end
         if (pz[k] !== 1'b0) begin bad++; $display("FAIL midrst_pad[%0d] got=%b want=0", k, pz[k]); end
      end
      model_reset();
      @(posedge tb_clk);
      @(negedge tb_clk);
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h3333_3333 + i);
      drive(1'b1, 1'b0, 1'b0, 32'h4444_4444);
      scoreboard_cycle();
      total++;
      if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b want=0", ov[0]); end
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      scoreboard_cycle();
      total++;
      if (ov[0] !== 1'b1) begin bad++; $display("FAIL midrst_refill got=%b want=1", ov[0]); end
      tick();
   endtask

   task automatic test_single_shift();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 1'b1, $urandom);
         scoreboard_cycle();
         if (i > 0) begin
            total += 2;
            if (ov[2] !== 1'b1) begin bad++; $display("FAIL s1_valid cyc=%0d got=%b want=1", i, ov[2]); end
            if (ir[2] !== 1'b1) begin bad++; $display("FAIL s1_in_ready cyc=%0d got=%b want=1", i, ir[2]); end
         end
         tick();
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, $urandom);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
   endtask

   initial begin
      model_reset();
      for (int k = 0; k < 3; k++) sr[k] = '0;
      test_reset();
      test_fill_hold();
      test_stream();
      test_two_byte();
      test_flush();
      test_reset_midword();
      test_single_shift();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
